// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: interlock and sequencing controller for a 5-stage pipeline
// (IF, ID, EX, MEM, WB).
//
// Purpose:
//   - Selects the forwarding source for each ID operand.
//   - Detects the load-use hazard and inserts a one-cycle stall.
//   - Flushes IF/ID when a taken branch or jump resolves in ID.
//   - Freezes the whole pipeline while data memory is busy.
//   - Runs a timeout FSM that latches a sticky fault when memory stays busy
//     too long.
//   - Keeps saturating counters of stall cycles and of redirect flushes.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   id_rs, id_rt               ID source registers
//   id_use_rs, id_use_rt       ID instruction actually reads rs / rt
//   ex_wreg, ex_m2reg, ex_rn   EX writes regfile / is a load / destination
//   mem_wreg, mem_m2reg, mem_rn  MEM writes regfile / is a load / destination
//   id_redirect                taken branch/jump/jal resolved in ID
//   mem_busy                   data memory not ready this cycle
//   pc_en, ifid_en, idex_en, exmem_en   pipeline register write enables
//   ifid_flush                 IF/ID loads a NOP at the next edge
//   idex_bubble                ID/EX loads a bubble at the next edge
//   fwda, fwdb                 operand selects: 00 regfile, 01 EX ALU,
//                              10 MEM ALU, 11 MEM load data
//   fault                      sticky memory-timeout fault
//   stall_cnt, flush_cnt       saturating performance counters

module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  input  logic             id_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [7:0] wait_cnt;
  logic       freeze;
  logic       lu;

  // Forwarding source for one ID operand. A load in EX cannot forward yet
  // (its data is not ready); that case falls through to MEM and is covered
  // by the load-use stall whenever the operand is actually used.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       exw,
    input logic       exm,
    input logic [4:0] exrn,
    input logic       mw,
    input logic       mm,
    input logic [4:0] mrn
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (exw && (exrn != 5'd0) && (exrn == src) && !exm) begin
      sel = 2'b01;
    end else if (mw && (mrn != 5'd0) && (mrn == src)) begin
      sel = mm ? 2'b11 : 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection: memory freeze and load-use match against EX.
  always_comb begin
    freeze = mem_busy || (state == FAULT);
    lu     = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
             ((id_use_rs && (ex_rn == id_rs)) || (id_use_rt && (ex_rn == id_rt)));
  end

  // Pipeline control outputs with priority freeze > load-use > redirect.
  // During reset everything runs and no forwarding is selected.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwda        = 2'b00;
    fwdb        = 2'b00;
    if (rst) begin
      fwda = 2'b00;
      fwdb = 2'b00;
    end else begin
      fwda = fwd_sel(id_rs, ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn);
      fwdb = fwd_sel(id_rt, ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn);
      if (freeze) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
      end else if (lu) begin
        // Hold PC and IF/ID, let the load move on, inject a bubble behind it.
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else if (id_redirect) begin
        ifid_flush = 1'b1;
      end else begin
        ifid_flush = 1'b0;
      end
    end
  end

  // Memory-wait timeout FSM, sticky fault and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      fault     <= 1'b0;
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= MWAIT;
            wait_cnt <= 8'd1;
          end else begin
            wait_cnt <= 8'd0;
          end
        end
        MWAIT: begin
          if (!mem_busy) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FAULT: begin
          fault <= 1'b1;
        end
        default: begin
          // Unreachable encoding: treat as corruption and lock up safely.
          state <= FAULT;
          fault <= 1'b1;
        end
      endcase

      if (lu && !freeze && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end

      if (ifid_flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share all inputs:
// dut_a uses the default parameters, dut_b uses TIMEOUT=4 and CNT_W=4 so the
// timeout and counter saturation are reachable in a short run.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rn, mem_rn;
  logic       id_use_rs, id_use_rt, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic       id_redirect, mem_busy;

  logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble, a_exmem_en, a_fault;
  logic [1:0]  a_fwda, a_fwdb;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble, b_exmem_en, b_fault;
  logic [1:0]  b_fwda, b_fwdb;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int errors = 0;
  int checks = 0;

  // Control vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en
  localparam logic [5:0] RUNV = 6'b110101;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] STL  = 6'b000111;
  localparam logic [5:0] FLU  = 6'b111101;

  typedef struct {
    string       tag;
    logic [5:0]  ctrl;
    logic [3:0]  fwd;
    logic        fa;
    logic [15:0] sa;
    logic [15:0] fla;
    logic [5:0]  bctrl;
    logic        fb;
    logic [3:0]  sb;
    logic [3:0]  flb;
  } exp_t;

  exp_t sb_q[$];

  logic [15:0] exp_sa, exp_fa;
  logic [3:0]  exp_sb, exp_fb;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .id_redirect(id_redirect), .mem_busy(mem_busy),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
    .idex_en(a_idex_en), .idex_bubble(a_idex_bubble), .exmem_en(a_exmem_en),
    .fwda(a_fwda), .fwdb(a_fwdb), .fault(a_fault),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .id_redirect(id_redirect), .mem_busy(mem_busy),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
    .idex_en(b_idex_en), .idex_bubble(b_idex_bubble), .exmem_en(b_exmem_en),
    .fwda(b_fwda), .fwdb(b_fwdb), .fault(b_fault),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s/%s got=%0h want=%0h", tag, what, got, want);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic exw, input logic exm, input logic [4:0] exrn,
                        input logic mw, input logic mm, input logic [4:0] mrn,
                        input logic redir, input logic busy);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_wreg = exw; ex_m2reg = exm; ex_rn = exrn;
    mem_wreg = mw; mem_m2reg = mm; mem_rn = mrn;
    id_redirect = redir; mem_busy = busy;
  endtask

  // One cycle: push expectation, sample mid-cycle, pop and compare, then
  // advance the expected counters for the coming edge.
  task automatic cyc(input string tag, input logic [5:0] ctrl, input logic [3:0] fwd, input logic fa,
                     input logic [5:0] bctrl, input logic fb,
                     input logic isa, input logic ifa, input logic isb, input logic ifb);
    exp_t e;
    exp_t p;
    e.tag = tag; e.ctrl = ctrl; e.fwd = fwd; e.fa = fa; e.sa = exp_sa; e.fla = exp_fa;
    e.bctrl = bctrl; e.fb = fb; e.sb = exp_sb; e.flb = exp_fb;
    sb_q.push_back(e);
    #2;
    p = sb_q.pop_front();
    chk(p.tag, "a_ctrl", 16'({a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble, a_exmem_en}), 16'(p.ctrl));
    chk(p.tag, "a_fwd", 16'({a_fwda, a_fwdb}), 16'(p.fwd));
    chk(p.tag, "a_fault", 16'(a_fault), 16'(p.fa));
    chk(p.tag, "a_stall", a_stall_cnt, p.sa);
    chk(p.tag, "a_flush", a_flush_cnt, p.fla);
    chk(p.tag, "b_ctrl", 16'({b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble, b_exmem_en}), 16'(p.bctrl));
    chk(p.tag, "b_fwd", 16'({b_fwda, b_fwdb}), 16'(p.fwd));
    chk(p.tag, "b_fault", 16'(b_fault), 16'(p.fb));
    chk(p.tag, "b_stall", 16'(b_stall_cnt), 16'(p.sb));
    chk(p.tag, "b_flush", 16'(b_flush_cnt), 16'(p.flb));
    if (isa && exp_sa != 16'hFFFF) exp_sa = exp_sa + 16'd1;
    if (ifa && exp_fa != 16'hFFFF) exp_fa = exp_fa + 16'd1;
    if (isb && exp_sb != 4'hF) exp_sb = exp_sb + 4'd1;
    if (ifb && exp_fb != 4'hF) exp_fb = exp_fb + 4'd1;
    @(negedge clk);
  endtask

  task automatic clr_exp();
    exp_sa = 16'd0; exp_fa = 16'd0; exp_sb = 4'd0; exp_fb = 4'd0;
  endtask

  initial begin
    clr_exp();
    rst = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset state, and reset overriding every hazard input
    cyc("rst_idle", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1);
    cyc("rst_gate", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Forwarding
    set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("fwd_ex_prio", RUNV, 4'b0100, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("fwd_mem_load", RUNV, 4'b1100, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
    cyc("fwd_ex_r0", RUNV, 4'b1010, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("fwd_ex_both", RUNV, 4'b0101, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("fwd_mem_r0", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use stall, then resolved by MEM load forwarding
    set_in(5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("lu_stall", STL, 4'b0000, 1'b0, STL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    set_in(5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    cyc("lu_resolved", RUNV, 4'b0011, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("lu_nouse", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Redirect suppressed by load-use, then taken
    set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("redir_vs_lu", STL, 4'b0000, 1'b0, STL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc("redir_flush", FLU, 4'b1100, 1'b0, FLU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("post_flush", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three-cycle memory wait with a concurrent load-use and redirect
    for (int i = 0; i < 3; i++) begin
      set_in(5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      cyc("mwait_busy", FRZ, 4'b0000, 1'b0, FRZ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    set_in(5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("mwait_release", STL, 4'b0000, 1'b0, STL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("mwait_run", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout: dut_b faults after the 4th busy cycle, dut_a does not
    for (int i = 0; i < 4; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc("tmo_busy", FRZ, 4'b0000, 1'b0, FRZ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("tmo_fault", RUNV, 4'b0000, 1'b0, FRZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("tmo_hold", FLU, 4'b0000, 1'b0, FRZ, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    cyc("tmo_rst", RUNV, 4'b0000, 1'b0, RUNV, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_exp();
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("post_rst", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a memory wait
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cyc("rmw_busy", FRZ, 4'b0000, 1'b0, FRZ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("rmw_rst", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("rmw_run", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation: 20 load-use cycles, dut_b counter stops at 15
    for (int i = 0; i < 20; i++) begin
      set_in(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc("sat_lu", STL, 4'b0000, 1'b0, STL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("sat_final", RUNV, 4'b0000, 1'b0, RUNV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_final", "a_stall20", a_stall_cnt, 16'd20);
    chk("sat_final", "b_stall15", 16'(b_stall_cnt), 16'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central interlock/sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Generates operand-forwarding selects for ID, the load-use stall, and the IF/ID flush on taken branch/jump.
- Generates the global freeze while data memory is busy, with a timeout FSM and saturating stall/flush performance counters.
- Drives the enable/bubble inputs of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- TIMEOUT, 64, max consecutive mem_busy cycles tolerated before FAULT (range 2..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_wreg  in  1  EX instruction writes the register file.
- ex_m2reg  in  1  EX instruction is a load.
- ex_rn  in  5  EX destination register.
- mem_wreg  in  1  MEM instruction writes the register file.
- mem_m2reg  in  1  MEM instruction is a load.
- mem_rn  in  5  MEM destination register.
- id_redirect  in  1  taken branch/jump/jal resolved in ID.
- mem_busy  in  1  data memory not ready this cycle.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads NOP at next edge.
- idex_en  out  1  ID/EX write enable.
- idex_bubble  out  1  ID/EX loads zero wreg/wmem/m2reg/jal at next edge.
- exmem_en  out  1  EX/MEM write enable.
- fwda  out  2  rs operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
- fwdb  out  2  rt operand select, same encoding.
- fault  out  1  sticky memory-timeout fault.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  redirect flushes, saturating.

Behaviour:
- FSM has three states: RUN, MWAIT, FAULT. Reset sets state RUN, wait_cnt 0, fault 0, stall_cnt 0, flush_cnt 0.
- While rst=1, the combinational outputs are: pc_en, ifid_en, idex_en and exmem_en at 1; ifid_flush and idex_bubble at 0; fwda and fwdb at 00.
- freeze = mem_busy or state==FAULT.
  - When freeze=1: pc_en, ifid_en, idex_en, exmem_en, ifid_flush and idex_bubble are all 0, and no counter updates.
  - Freeze is combinational, so it takes effect in the same cycle mem_busy rises.
- RUN to MWAIT when mem_busy=1; wait_cnt <= 1.
- MWAIT:
  - mem_busy=0: go to RUN and clear wait_cnt. The pipeline advances in that same cycle.
  - mem_busy=1 and wait_cnt==TIMEOUT-1: go to FAULT and set fault=1.
  - Otherwise wait_cnt increments.
- FAULT is held until rst; mem_busy is ignored.
- Forwarding (rs shown; rt is identical using id_rt):
  - EX match = ex_wreg, ex_rn!=0, ex_rn==id_rs. Gives 01 if ex_m2reg=0.
  - Otherwise MEM match = mem_wreg, mem_rn!=0, mem_rn==id_rs. Gives 11 if mem_m2reg=1, else 10.
  - Otherwise 00.
  - EX has priority over MEM.
  - Forwarding is computed independent of use bits; the use bits gate only the stall.
- Load-use stall lu = ex_wreg, ex_m2reg, ex_rn!=0, and ((id_use_rs and ex_rn==id_rs) or (id_use_rt and ex_rn==id_rt)).
  - With lu=1 and no freeze: pc_en=0, ifid_en=0, idex_bubble=1; exmem_en=1, idex_en=1.
  - The stall lasts exactly 1 cycle, because the load moves to MEM and forwarding then selects 11.
- Redirect: id_redirect=1, lu=0 and no freeze gives ifid_flush=1; PC and IF/ID enables stay 1.
  - If lu=1, the redirect is suppressed because its operands are stale; it re-evaluates next cycle.
- Priority: freeze > lu > redirect.
- Counters:
  - stall_cnt increments on each lu cycle where freeze=0.
  - flush_cnt increments on each ifid_flush cycle.
  - Both hold at 2^CNT_W-1.
- Reset mid-MWAIT or in FAULT returns to RUN at the next edge with all counters cleared.

Test Plan:
- Forwarding priority: ex_wreg=1, ex_rn=5; mem_wreg=1, mem_rn=5, mem_m2reg=1; id_rs=5 -> fwda=01. Drop ex_wreg -> fwda=11. Set ex_rn=0 with ex_wreg=1 -> no EX forward.
- Load-use: lw to r8 in EX (ex_m2reg=1, ex_rn=8), id_rt=8, id_use_rt=1 -> 1 cycle of pc_en=0, ifid_en=0, idex_bubble=1. Next cycle the load is in MEM, fwdb=11, no stall, stall_cnt=1.
- Redirect vs stall: lu=1 and id_redirect=1 together -> ifid_flush=0, flush_cnt unchanged. Next cycle (lu=0, id_redirect=1) -> ifid_flush=1, flush_cnt=1.
- Memory wait: mem_busy high for 3 cycles with TIMEOUT=64 -> all enables 0 for exactly those 3 cycles, state returns to RUN, fault=0. A concurrent lu must not change stall_cnt during the freeze.
- Timeout: TIMEOUT=4, mem_busy held -> fault=1 after the 4th busy cycle, enables stay 0 after mem_busy drops. Assert rst for 1 cycle -> fault=0, counters 0, state RUN.
- Saturation: CNT_W=4, force 20 lu cycles -> stall_cnt=15.
